// File: rtl/can_rx_frame_buffer.sv
// can_rx_frame_buffer
//   Receive-side frame buffer for the CAN path. Collects the per-byte stream from the
//   CAN controller into whole frames (1..MAX_BYTES bytes) held in a FRAME_SLOTS-deep ring.
//   Frames are replayed to the host side as a byte valid/ready stream. Only complete,
//   well-formed frames are ever presented on the output.
//
// Ports
//   clk, reset_n                      clock, asynchronous active-low reset
//   rx_valid, rx_last, rx_data        byte stream from CAN controller (no backpressure)
//   out_valid, out_ready              head-frame byte handshake
//   out_data, out_last, out_len       head-frame byte, final-byte flag, head-frame length
//   frame_count                       committed frames not yet fully read
//   drop_cnt                          saturating count of dropped frames
//   err_oversize, err_timeout         1-cycle error pulses
module can_rx_frame_buffer #(
    parameter int unsigned FRAME_SLOTS = 4,
    parameter int unsigned MAX_BYTES   = 8,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           rx_valid,
    input  logic                           rx_last,
    input  logic [7:0]                     rx_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [7:0]                     out_data,
    output logic                           out_last,
    output logic [3:0]                     out_len,
    output logic [$clog2(FRAME_SLOTS):0]   frame_count,
    output logic [7:0]                     drop_cnt,
    output logic                           err_oversize,
    output logic                           err_timeout
);

    localparam int unsigned PTR_W  = $clog2(FRAME_SLOTS);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BYTE_W = $clog2(MAX_BYTES);
    localparam int unsigned IDX_W  = BYTE_W + 1;
    localparam int unsigned TMR_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {WIdle, WFill, WDiscard} wstate_e;

    wstate_e            state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   rd_idx_q;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [7:0]         drop_q;
    logic               err_ovr_q, err_tmo_q;

    logic [7:0]         mem [FRAME_SLOTS][MAX_BYTES];
    logic [3:0]         len [FRAME_SLOTS];

    logic               full;
    logic               wr_en;
    logic [BYTE_W-1:0]  wr_addr;
    logic               commit;
    logic               drop;
    logic               set_ovr;
    logic               set_tmo;
    logic               at_max;
    logic               tmo_hit;
    logic               rd_last;
    logic               release_frame;
    logic [3:0]         rd_len;

    // Full is sampled only when a frame starts; an in-flight frame already owns its slot.
    assign full    = (count_q == CNT_W'(FRAME_SLOTS));
    assign at_max  = (idx_q == IDX_W'(MAX_BYTES));
    assign tmo_hit = (timer_q == TMR_W'(TIMEOUT - 1));

    // ---------------------------------------------------------------------------------
    // Write FSM: state register
    // ---------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Write FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            WIdle: begin
                if (rx_valid && !rx_last) begin
                    state_d = full ? WDiscard : WFill;
                end
            end
            WFill: begin
                if (rx_valid) begin
                    if (rx_last) begin
                        state_d = WIdle;
                    end else if (at_max) begin
                        state_d = WDiscard;
                    end
                end else if (tmo_hit) begin
                    state_d = WIdle;
                end
            end
            WDiscard: begin
                if (rx_valid && rx_last) begin
                    state_d = WIdle;
                end
            end
            default: state_d = WIdle;
        endcase
    end

    // Write FSM: datapath control
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        commit  = 1'b0;
        drop    = 1'b0;
        set_ovr = 1'b0;
        set_tmo = 1'b0;
        idx_d   = idx_q;
        timer_d = timer_q;
        case (state_q)
            WIdle: begin
                if (rx_valid) begin
                    if (full) begin
                        drop = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        idx_d   = IDX_W'(1);
                        timer_d = '0;
                        commit  = rx_last;
                    end
                end
            end
            WFill: begin
                if (rx_valid) begin
                    timer_d = '0;
                    if (at_max) begin
                        set_ovr = 1'b1;
                        drop    = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        wr_addr = idx_q[BYTE_W-1:0];
                        idx_d   = idx_q + IDX_W'(1);
                        commit  = rx_last;
                    end
                end else if (tmo_hit) begin
                    set_tmo = 1'b1;
                    drop    = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------------------------
    // Storage (not reset)
    // ---------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q][wr_addr] <= rx_data;
        end
        // idx_d already holds the byte count including the byte being captured.
        if (commit) begin
            len[wr_ptr_q] <= 4'(idx_d);
        end
    end

    // ---------------------------------------------------------------------------------
    // Read side
    // ---------------------------------------------------------------------------------
    assign rd_len        = len[rd_ptr_q];
    assign rd_last       = (rd_idx_q == (IDX_W'(rd_len) - IDX_W'(1)));
    assign out_valid     = (count_q != '0);
    // Gated so the unreset storage never shows through while idle.
    assign out_data      = out_valid ? mem[rd_ptr_q][rd_idx_q[BYTE_W-1:0]] : 8'h00;
    assign out_len       = out_valid ? rd_len : 4'h0;
    assign out_last      = out_valid & rd_last;
    assign release_frame = out_valid & out_ready & rd_last;

    always_comb begin
        count_d = count_q;
        unique case ({commit, release_frame})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // ---------------------------------------------------------------------------------
    // Sequential state
    // ---------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            idx_q     <= '0;
            rd_idx_q  <= '0;
            timer_q   <= '0;
            count_q   <= '0;
            drop_q    <= '0;
            err_ovr_q <= 1'b0;
            err_tmo_q <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            count_q   <= count_d;
            err_ovr_q <= set_ovr;
            err_tmo_q <= set_tmo;
            if (commit) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (drop && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
            if (out_valid && out_ready) begin
                if (rd_last) begin
                    rd_idx_q <= '0;
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end else begin
                    rd_idx_q <= rd_idx_q + IDX_W'(1);
                end
            end
        end
    end

    assign frame_count  = count_q;
    assign drop_cnt     = drop_q;
    assign err_oversize = err_ovr_q;
    assign err_timeout  = err_tmo_q;

endmodule
